display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for a multi-digit, common-anode 7-segment display bank. It accepts 32-bit values through a valid/ready handshake and buffers them so that updates never tear mid-frame. It cycles the anode enables across all hex digits and drives the shared segment bus. It sits between the datapath's debug/result tap and the board display pins, and supersedes the single-digit static decode.

## Interface
- `DIGITS`, default 8: number of hex digits scanned. Legal range 1..8. Digit i displays `load_data[4i+3:4i]`.
- `TICK_DIV`, default 50000: clock cycles per digit slot. Must be ≥ 2.
- `clk`, in, 1: single system clock. All state is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: requester has a value on `load_data`.
- `load_ready`, out, 1: controller can accept a value. A transfer occurs on a rising edge where `load_valid && load_ready`.
- `load_data`, in, 32: value to display.
- `blank_lz`, in, 1: leading-zero blanking enable. Sampled every cycle.
- `anodes`, out, DIGITS: digit enables, active-low. Bit i = digit i.
- `segments`, out, 7: segments {g,f,e,d,c,b,a}, active-low. Hex glyph encoding: 0=1000000, 1=1111001, … 8=0000000, F=0001110.

## Operation
- Reset values: `anodes` all 1, `segments` = 7'b1111111, `load_ready` = 1, state BLANK, digit index 0, dwell counter 0, pending buffer empty, shadow register 0.
- States:
  - BLANK: nothing loaded yet. Outputs stay all-off. On a transfer, `load_data` goes directly to the shadow register and the state moves to SCAN with digit 0 and counter 0.
  - SCAN: continuous scanning. There is no path back to BLANK except reset.
- Buffering in SCAN:
  - A transfer writes the one-entry pending buffer. `load_ready` = !pending_full, and it is a registered output.
  - At the frame boundary, the pending contents move to the shadow register and pending clears. The frame boundary is the last cycle of digit DIGITS-1's slot.
- Simultaneous events:
  - A transfer on the frame-boundary cycle with pending empty bypasses pending and writes the shadow register directly. `load_ready` stays 1.
  - If pending is full, `load_ready` = 0, so no transfer can coincide with the pending→shadow move.
- Scanning:
  - The dwell counter runs 0..TICK_DIV-1. On wrap, the digit index increments modulo DIGITS.
  - Counter value 0 is a dead-time cycle: all anodes off and segments off, to prevent ghosting.
  - For counter values 1..TICK_DIV-1, `anodes[idx]` = 0 and `segments` = glyph(shadow nibble idx).
- Leading-zero blanking: when `blank_lz` = 1, digit i > 0 is blanked if shadow nibbles i..DIGITS-1 are all zero. A blanked digit holds its anode high for the whole slot. Digit 0 is never blanked.
- Width rules:
  - Only nibbles 0..DIGITS-1 are used; upper bits of `load_data` are ignored.
  - Digit index width is clog2(DIGITS), minimum 1. Counter width is clog2(TICK_DIV).
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). Pending and shadow contents are lost.

## Timing
- `anodes` and `segments` are registered. They reflect the counter/index state with 1 cycle of latency.
- First display: a transfer in BLANK at edge E0 gives the dead cycle at E1. `anodes[0]` goes low at E2 and stays low for TICK_DIV-1 cycles.
- Frame period is exactly DIGITS×TICK_DIV cycles. Each unblanked digit is lit for exactly TICK_DIV-1 consecutive cycles per frame.
- Display latency in SCAN: a value accepted during frame n is first visible in frame n+1, starting at digit 0.
- `load_ready` falls the cycle after a transfer into pending. It rises the cycle after the frame-boundary move.
- The requester may hold `load_valid` high indefinitely. `load_data` must be stable while `load_valid && !load_ready`.

## Structure
- Package `display_pkg` contains:
  - `SEG_BLANK` = 7'b1111111;
  - the `seg_t` typedef (logic [6:0]);
  - the `scan_state_t` enum {BLANK, SCAN};
  - the `hex_glyph` constant function, which is the 16-entry encoding above.
- One sub-module, `hex_to_seg`: a combinational 4-bit nibble → seg_t decoder. It is instantiated once and fed the selected shadow nibble.
- Everything else lives in one file: the FSM, dwell counter, digit index, pending/shadow registers, blanking logic and output registers.

## Test plan
Simulate with DIGITS=8, TICK_DIV=4.
- Reset/BLANK:
  - Hold `rst_n` = 0, then release with no `load_valid` for 100 cycles.
  - Required: `anodes` = 8'hFF, `segments` = 7'h7F and `load_ready` = 1 throughout.
- First load, scan order:
  - Load 32'h89ABCDEF in BLANK.
  - Required: `anodes` = 8'hFE with `segments` = 0001110 (F) for 3 cycles starting 2 edges after the transfer, then 1 all-off cycle, then 8'hFD with 0000110 (E). Frame period is 32 cycles.
- Leading-zero blanking:
  - Load 32'h0000_00A5 with `blank_lz` = 1.
  - Required: only anodes[0] (5) and anodes[1] (A) ever go low; anodes[7:2] stay 1.
  - Then load 32'h0 with `blank_lz` = 1. Required: digit 0 shows 1000000 and all other digits are blank.
- Handshake backpressure:
  - In SCAN, transfer 32'h1111_1111 mid-frame.
  - Required: `load_ready` = 0 until the frame boundary, the old value finishes the frame, and 1s appear from the next digit 0.
  - A second valid 32'h2222_2222 is held off and then accepted.
- Boundary bypass: a transfer exactly on the digit-7 last cycle with pending empty must be shown from the immediately following digit 0, with `load_ready` never dropping.
- Async reset mid-scan: assert `rst_n` = 0 asynchronously mid-dwell, with pending full.
  - Required: outputs go all-off before the next clock edge.
  - After release: state is BLANK and `load_ready` = 1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and the hex glyph table for the 7-segment scan controller.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic {
    BLANK,
    SCAN
  } scan_state_t;

  function automatic seg_t hex_glyph(input logic [3:0] nib);
    seg_t glyph;
    glyph = SEG_BLANK;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = hex_glyph(nib);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed hex display scanner with a tear-free pending/shadow update path.
// Outputs are registered and lag the counter/index state by one cycle.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] anodes,
  output seg_t              segments
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int VAL_W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pend_full_q, pend_full_d;
  logic [VAL_W-1:0]  pend_q, pend_d;
  logic [VAL_W-1:0]  shadow_q, shadow_d;
  logic              ready_q, ready_d;
  logic [DIGITS-1:0] anodes_q, anodes_d;
  seg_t              segments_q, segments_d;

  logic              xfer;
  logic              frame_end;
  logic [3:0]        nib_sel;
  seg_t              glyph;
  logic              lit;
  logic [DIGITS-1:0] nib_zero;
  logic [DIGITS-1:0] blank_mask;

  assign xfer      = load_valid && ready_q;
  assign frame_end = (state_q == SCAN) && (idx_q == LAST_IDX) && (cnt_q == LAST_CNT);

  // A digit is a blanking candidate when it and every digit above it are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign nib_zero[gi]   = (shadow_q[4*gi +: 4] == 4'd0);
    assign blank_mask[gi] = blank_lz & (&nib_zero[DIGITS-1:gi]);
  end

  assign nib_sel = shadow_q[4*idx_q +: 4];

  hex_to_seg u_hex_to_seg (
    .nib (nib_sel),
    .seg (glyph)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    shadow_d    = shadow_q;

    case (state_q)
      BLANK: begin
        if (xfer) begin
          shadow_d = load_data[VAL_W-1:0];
          state_d  = SCAN;
          cnt_d    = '0;
          idx_d    = '0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // ready is low whenever pending is full, so the move and a transfer never collide.
        if (frame_end) begin
          if (pend_full_q) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            shadow_d = load_data[VAL_W-1:0];
          end
        end else if (xfer) begin
          pend_d      = load_data[VAL_W-1:0];
          pend_full_d = 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase

    ready_d = !pend_full_d;
  end

  // Counter value 0 is the dead-time slot between digits.
  always_comb begin
    lit = (state_q == SCAN) && (cnt_q != '0) &&
          !(blank_mask[idx_q] && (idx_q != '0));
    anodes_d   = lit ? ~(DIGITS'(1) << idx_q) : '1;
    segments_d = lit ? glyph : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      shadow_q    <= '0;
      ready_q     <= 1'b1;
      anodes_q    <= '1;
      segments_q  <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      ready_q     <= ready_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
    end
  end

  assign load_ready = ready_q;
  assign anodes     = anodes_q;
  assign segments   = segments_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIGITS=8, TICK_DIV=4): per-cycle
// scoreboard against a frame-position model, glyph/blanking vector table, corner sequences.
module tb_display_scan_ctrl;

  localparam int DIGITS   = 8;
  localparam int TICK_DIV = 4;
  localparam int FRAME    = DIGITS * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  anodes;
  logic [6:0]  segments;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .anodes     (anodes),
    .segments   (segments)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       rdy;
  } exp_t;

  typedef struct packed {
    logic [31:0]     data;
    logic            lz;
    logic [7:0][6:0] seg;   // per digit, 7F means the digit must never light
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: frame position counter plus buffer contents.
  bit          m_scan;
  int          m_t;
  logic [31:0] m_shadow, m_pend;
  bit          m_pfull, m_ready;

  logic [7:0] obs_an;
  logic [6:0] obs_seg;
  logic       obs_rdy;
  bit         last_xfer;

  logic [7:0] lit_cnt [8];
  logic [6:0] cap_seg [8];

  function automatic logic [6:0] tb_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting, got no event, required event", name);
  endtask

  task automatic m_reset();
    m_scan = 0; m_t = 0; m_shadow = '0; m_pend = '0; m_pfull = 0; m_ready = 1;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs, predict the post-edge outputs, compare after the edge.
  task automatic step(input logic v, input logic [31:0] d);
    exp_t e;
    int dig, ph;
    bit blk, bnd;
    load_valid = v;
    load_data  = d;
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    if (m_scan) begin
      dig = m_t / TICK_DIV;
      ph  = m_t % TICK_DIV;
      blk = blank_lz && (dig > 0) && ((m_shadow >> (4 * dig)) == 0);
      if (ph != 0 && !blk) begin
        e.an  = ~(8'(1) << dig);
        e.seg = tb_glyph(m_shadow[4*dig +: 4]);
      end
    end
    last_xfer = v && m_ready;
    if (!m_scan) begin
      if (last_xfer) begin m_shadow = d; m_scan = 1; m_t = 0; end
    end else begin
      bnd = (m_t == FRAME - 1);
      if (bnd) begin
        if (m_pfull) begin m_shadow = m_pend; m_pfull = 0; end
        else if (last_xfer) m_shadow = d;
      end else if (last_xfer) begin
        m_pend = d; m_pfull = 1;
      end
      m_t = (m_t + 1) % FRAME;
    end
    m_ready = !m_pfull;
    e.rdy = m_ready;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    obs_an = anodes; obs_seg = segments; obs_rdy = load_ready;
    e = sb_q.pop_front();
    chk($sformatf("sb@%0d", cyc), 32'({obs_an, obs_seg, obs_rdy}), 32'({e.an, e.seg, e.rdy}));
  endtask

  task automatic load_val(input logic [31:0] d);
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      step(1'b1, d);
      done = last_xfer;
    end
    if (!done) timeout_fail("load_accept");
  endtask

  task automatic wait_frame(input logic [31:0] d);
    for (int k = 0; k < 200 && !(m_scan && m_shadow == d && !m_pfull && m_t == 0); k++)
      step(1'b0, '0);
    if (!(m_shadow == d && m_t == 0)) timeout_fail("frame_start");
  endtask

  task automatic adv_to(input int t);
    for (int k = 0; k < 100 && m_t != t; k++) step(1'b0, '0);
    if (m_t != t) timeout_fail("advance");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_fe, lowcnt;
    logic [6:0] ex_seg;

    vecs[0] = '{32'h89ABCDEF, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
    vecs[1] = '{32'h000000A5, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
    vecs[2] = '{32'h00000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{32'h000000A5, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}};
    vecs[4] = '{32'h01234567, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[5] = '{32'h00100300, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h30, 7'h40, 7'h40}};

    // Reset and idle BLANK
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_anodes", 32'(anodes), 32'h0FF);
    chk("rst_segments", 32'(segments), 32'h07F);
    chk("rst_ready", 32'(load_ready), 32'h1);
    rst_n = 1'b1;
    repeat (100) step(1'b0, '0);

    // First load and scan order
    step(1'b1, 32'h89ABCDEF);
    step(1'b0, '0);
    chk("first_dead", 32'({obs_an, obs_seg}), 32'({8'hFF, 7'h7F}));
    first_fe = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0);
      chk($sformatf("first_d0_%0d", k), 32'({obs_an, obs_seg}), 32'({8'hFE, 7'h0E}));
    end
    step(1'b0, '0);
    chk("first_gap", 32'({obs_an, obs_seg}), 32'({8'hFF, 7'h7F}));
    step(1'b0, '0);
    chk("first_d1", 32'({obs_an, obs_seg}), 32'({8'hFD, 7'h06}));
    for (int k = 0; k < 64 && obs_an != 8'hFE; k++) step(1'b0, '0);
    if (obs_an != 8'hFE) timeout_fail("frame_period");
    else chk("frame_period", 32'(cyc - first_fe), 32'(FRAME));

    // Glyph and leading-zero vectors
    for (int r = 0; r < 6; r++) begin
      blank_lz = vecs[r].lz;
      load_val(vecs[r].data);
      wait_frame(vecs[r].data);
      for (int i = 0; i < 8; i++) begin lit_cnt[i] = '0; cap_seg[i] = 7'h7F; end
      for (int f = 0; f < FRAME; f++) begin
        step(1'b0, '0);
        for (int i = 0; i < 8; i++)
          if (!obs_an[i]) begin lit_cnt[i]++; cap_seg[i] = obs_seg; end
      end
      for (int i = 0; i < 8; i++) begin
        ex_seg = vecs[r].seg[i];
        chk($sformatf("vec%0d_dig%0d", r, i), 32'({lit_cnt[i], cap_seg[i]}),
            32'({(ex_seg == 7'h7F) ? 8'd0 : 8'd3, ex_seg}));
      end
    end
    blank_lz = 1'b0;

    // Backpressure: mid-frame transfer, second value held off
    adv_to(10);
    step(1'b1, 32'h11111111);
    chk("bp_ready_fall", 32'(obs_rdy), 32'h0);
    lowcnt = 1;
    step(1'b0, '0);
    if (!obs_rdy) lowcnt++;
    for (int k = 0; k < 64 && !obs_rdy; k++) begin
      step(1'b1, 32'h22222222);
      if (!obs_rdy) lowcnt++;
    end
    chk("bp_low_cycles", 32'(lowcnt), 32'd21);
    step(1'b1, 32'h22222222);
    chk("bp_second_accept", 32'({obs_an, obs_seg, obs_rdy}), 32'({8'hFF, 7'h7F, 1'b0}));
    step(1'b0, '0);
    chk("bp_ones_d0", 32'({obs_an, obs_seg}), 32'({8'hFE, 7'h79}));
    wait_frame(32'h22222222);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("bp_twos_d0", 32'({obs_an, obs_seg}), 32'({8'hFE, 7'h24}));

    // Boundary bypass on the last cycle of digit 7
    for (int k = 0; k < 100 && !(m_t == FRAME - 1 && !m_pfull); k++) step(1'b0, '0);
    step(1'b1, 32'h33333333);
    chk("byp_ready", 32'(obs_rdy), 32'h1);
    step(1'b0, '0);
    chk("byp_dead", 32'({obs_an, obs_seg, obs_rdy}), 32'({8'hFF, 7'h7F, 1'b1}));
    step(1'b0, '0);
    chk("byp_d0", 32'({obs_an, obs_seg, obs_rdy}), 32'({8'hFE, 7'h30, 1'b1}));

    // Asynchronous reset mid-dwell with pending full
    adv_to(5);
    step(1'b1, 32'h44444444);
    chk("ar_pend_full", 32'(obs_rdy), 32'h0);
    step(1'b0, '0);
    load_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("ar_immediate", 32'({anodes, segments, load_ready}), 32'({8'hFF, 7'h7F, 1'b1}));
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("ar_held", 32'({anodes, segments, load_ready}), 32'({8'hFF, 7'h7F, 1'b1}));
    rst_n = 1'b1;
    repeat (10) step(1'b0, '0);
    step(1'b1, 32'h55555555);
    step(1'b0, '0);
    chk("ar_reload_dead", 32'({obs_an, obs_seg}), 32'({8'hFF, 7'h7F}));
    step(1'b0, '0);
    chk("ar_reload_d0", 32'({obs_an, obs_seg}), 32'({8'hFE, 7'h12}));
    repeat (40) step(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
